// File: rtl/seg7_scan_if.sv
// Bundle of the multiplexed 7-segment bus and the reconstructed frame outputs.
// The master drives the panel side; the slave is the scan decoder.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    err_clr;
    logic [4*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]   blank_out;
    logic [NUM_DIGITS-1:0]   digit_err;
    logic                    frame_valid;
    logic [1:0]              err_status;

    modport master (
        output seg, dig_en, err_clr,
        input  bcd_out, blank_out, digit_err, frame_valid, err_status
    );

    modport slave (
        input  seg, dig_en, err_clr,
        output bcd_out, blank_out, digit_err, frame_valid, err_status
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus, debounces each digit slot, decodes it back
// to BCD and publishes complete frames atomically with a one-cycle valid pulse.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input logic         clk,
    input logic         rst,
    seg7_scan_if.slave  bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = 7 + NUM_DIGITS;
    localparam logic [7:0]    STABLE = 8'(STABLE_CYCLES);
    localparam logic [IW-1:0] LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {SEEK, COLLECT, PUBLISH} state_t;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] s);
        case (s)
            7'b1111110: return '{4'd0, 1'b0, 1'b0};
            7'b0110000: return '{4'd1, 1'b0, 1'b0};
            7'b1101101: return '{4'd2, 1'b0, 1'b0};
            7'b1111001: return '{4'd3, 1'b0, 1'b0};
            7'b0110011: return '{4'd4, 1'b0, 1'b0};
            7'b1011011: return '{4'd5, 1'b0, 1'b0};
            7'b1011111: return '{4'd6, 1'b0, 1'b0};
            7'b1110000: return '{4'd7, 1'b0, 1'b0};
            7'b1111111: return '{4'd8, 1'b0, 1'b0};
            7'b1111011: return '{4'd9, 1'b0, 1'b0};
            7'b0000000: return '{4'hF, 1'b1, 1'b0};
            default:    return '{4'hF, 1'b0, 1'b1};
        endcase
    endfunction

    state_t                  state, state_nxt;
    logic [IW-1:0]           expected, exp_nxt;
    logic [SW-1:0]           samp;
    logic [7:0]              run_cnt, run_cnt_nxt;
    logic                    changed, capture, onehot, multihot, cap_ok, cap_bad;
    logic [IW-1:0]           k;
    dec_t                    dec;
    logic                    store, seq_err, pat_err;
    logic [4*NUM_DIGITS-1:0] sh_bcd, bcd_q;
    logic [NUM_DIGITS-1:0]   sh_blank, sh_err, blank_q, derr_q;
    logic                    fv_q;
    logic [1:0]              err_q;

    // Capture uses the incoming sample so STABLE_CYCLES=1 captures on the change edge.
    always_comb begin
        changed     = {bus.seg, bus.dig_en} != samp;
        run_cnt_nxt = changed ? 8'd1 : ((run_cnt < STABLE) ? run_cnt + 8'd1 : run_cnt);
        capture     = (run_cnt_nxt == STABLE) && (changed || run_cnt != STABLE);
    end

    always_comb begin
        onehot   = $onehot(bus.dig_en);
        multihot = (bus.dig_en != '0) && !onehot;
        k        = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.dig_en[i]) k = IW'(i);
        end
        cap_ok  = capture && onehot;
        cap_bad = capture && multihot;
        dec     = decode(bus.seg);
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        exp_nxt   = expected;
        store     = 1'b0;
        seq_err   = 1'b0;
        case (state)
            SEEK: begin
                if (cap_ok && k == '0) begin
                    store = 1'b1;
                    if (NUM_DIGITS == 1) begin
                        state_nxt = PUBLISH;
                    end else begin
                        state_nxt = COLLECT;
                        exp_nxt   = IW'(1);
                    end
                end
            end
            COLLECT: begin
                if (cap_ok) begin
                    if (k == expected) begin
                        store = 1'b1;
                        if (k == LAST) state_nxt = PUBLISH;
                        else           exp_nxt   = expected + IW'(1);
                    end else if (k == expected - IW'(1)) begin
                        store = 1'b1;
                    end else if (k == '0) begin
                        store   = 1'b1;
                        exp_nxt = IW'(1);
                    end else begin
                        seq_err   = 1'b1;
                        state_nxt = SEEK;
                    end
                end
            end
            PUBLISH: state_nxt = SEEK;
            default: state_nxt = SEEK;
        endcase
        if (cap_bad) seq_err = 1'b1;
        pat_err = store && dec.err;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow frame is reset as well, so a discarded partial frame
            // can never surface in a later publish.
            state    <= SEEK;
            expected <= '0;
            samp     <= '0;
            run_cnt  <= '0;
            sh_bcd   <= '0;
            sh_blank <= '0;
            sh_err   <= '0;
            bcd_q    <= '0;
            blank_q  <= '0;
            derr_q   <= '0;
            fv_q     <= 1'b0;
            err_q    <= '0;
        end else begin
            state    <= state_nxt;
            expected <= exp_nxt;
            samp     <= {bus.seg, bus.dig_en};
            run_cnt  <= run_cnt_nxt;
            if (store) begin
                sh_bcd[4*int'(k) +: 4] <= dec.nib;
                sh_blank[k]            <= dec.blank;
                sh_err[k]              <= dec.err;
            end
            fv_q <= (state == PUBLISH);
            if (state == PUBLISH) begin
                bcd_q   <= sh_bcd;
                blank_q <= sh_blank;
                derr_q  <= sh_err;
            end
            // A new error in the same cycle as err_clr still leaves its bit set.
            err_q <= (bus.err_clr ? 2'b00 : err_q) | {seq_err, pat_err};
        end
    end

    assign bus.bcd_out     = bcd_q;
    assign bus.blank_out   = blank_q;
    assign bus.digit_err   = derr_q;
    assign bus.frame_valid = fv_q;
    assign bus.err_status  = err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (4 digits, 3-sample debounce) with
// hand-computed expected frames.
module tb_seg7_scan_decoder;
    localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011};
    localparam logic [6:0] BAD   = 7'b1001001;
    localparam logic [6:0] GLINT = 7'b0000000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   fv_count;

    seg7_scan_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge, then the next inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.frame_valid) fv_count++;
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] en, input int n);
        bus.seg    = s;
        bus.dig_en = en;
        repeat (n) tick();
    endtask

    task automatic show(input int k, input logic [6:0] s);
        drive(s, 4'(1 << k), 5);
        drive(7'b0, 4'b0, 1);
    endtask

    task automatic check_frame(input string tag, input int fv, input logic [15:0] bcd,
                               input logic [3:0] blank, input logic [3:0] derr,
                               input logic [1:0] err);
        check({tag, " frames"}, 32'(fv_count), 32'(fv));
        check({tag, " bcd"},    32'(bus.bcd_out), 32'(bcd));
        check({tag, " blank"},  32'(bus.blank_out), 32'(blank));
        check({tag, " derr"},   32'(bus.digit_err), 32'(derr));
        check({tag, " err"},    32'(bus.err_status), 32'(err));
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        fv_count    = 0;
        rst         = 1'b1;
        bus.seg     = '0;
        bus.dig_en  = '0;
        bus.err_clr = 1'b0;
        repeat (3) tick();
        check("reset fv", 32'(bus.frame_valid), 32'h0);
        check_frame("reset", 0, 16'h0000, 4'b0000, 4'b0000, 2'b00);
        rst = 1'b0;
        drive(7'b0, 4'b0, 4);

        // Ordered frame 1,2,3,4 with the latency of the last digit checked edge by edge.
        show(0, PAT[1]);
        show(1, PAT[2]);
        show(2, PAT[3]);
        bus.seg    = PAT[4];
        bus.dig_en = 4'b1000;
        tick();
        check("lat E fv", 32'(bus.frame_valid), 32'h0);
        tick();
        tick();
        check("lat E+2 fv", 32'(bus.frame_valid), 32'h0);
        check("lat E+2 bcd", 32'(bus.bcd_out), 32'h0);
        tick();
        check("lat E+3 fv", 32'(bus.frame_valid), 32'h1);
        tick();
        check("fv pulse width", 32'(bus.frame_valid), 32'h0);
        drive(7'b0, 4'b0, 1);
        check_frame("ordered", 1, 16'h4321, 4'b0000, 4'b0000, 2'b00);
        drive(7'b0, 4'b0, 6);
        check_frame("hold", 1, 16'h4321, 4'b0000, 4'b0000, 2'b00);

        // Glitch on digit 1 is too short to capture.
        show(0, PAT[5]);
        drive(PAT[3], 4'b0010, 2);
        show(1, PAT[2]);
        show(2, PAT[7]);
        show(3, PAT[9]);
        check_frame("glitch", 2, 16'h9725, 4'b0000, 4'b0000, 2'b00);

        // Undecodable pattern on digit 2.
        show(0, PAT[0]);
        show(1, PAT[1]);
        show(2, BAD);
        check("pat err early", 32'(bus.err_status), 32'h1);
        show(3, PAT[8]);
        check_frame("pat err", 3, 16'h8F10, 4'b0000, 4'b0100, 2'b01);
        show(0, PAT[1]);
        show(1, PAT[2]);
        show(2, PAT[3]);
        show(3, PAT[4]);
        check_frame("sticky", 4, 16'h4321, 4'b0000, 4'b0000, 2'b01);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("err_clr", 32'(bus.err_status), 32'h0);

        // Blank digit 3.
        show(0, PAT[9]);
        show(1, PAT[8]);
        show(2, PAT[7]);
        show(3, GLINT);
        check_frame("blank", 5, 16'hF789, 4'b1000, 4'b0000, 2'b00);

        // Out-of-order sequence 0,1,3 then a full frame.
        show(0, PAT[6]);
        show(1, PAT[6]);
        show(3, PAT[6]);
        check_frame("seq err", 5, 16'hF789, 4'b1000, 4'b0000, 2'b10);
        show(0, PAT[0]);
        show(1, PAT[1]);
        show(2, PAT[2]);
        show(3, PAT[3]);
        check_frame("after seq", 6, 16'h3210, 4'b0000, 4'b0000, 2'b10);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        drive(PAT[8], 4'b0110, 3);
        drive(7'b0, 4'b0, 1);
        check_frame("multihot", 6, 16'h3210, 4'b0000, 4'b0000, 2'b10);

        // Reset mid-frame, then a fragment that does not start at digit 0.
        show(0, PAT[5]);
        show(1, PAT[6]);
        rst = 1'b1;
        tick();
        check("in reset fv", 32'(bus.frame_valid), 32'h0);
        check_frame("in reset", 6, 16'h0000, 4'b0000, 4'b0000, 2'b00);
        tick();
        rst = 1'b0;
        show(2, PAT[2]);
        show(3, PAT[3]);
        check_frame("fragment", 6, 16'h0000, 4'b0000, 4'b0000, 2'b00);
        show(0, PAT[7]);
        show(1, PAT[8]);
        show(2, PAT[9]);
        show(3, PAT[0]);
        check_frame("post reset", 7, 16'h0987, 4'b0000, 4'b0000, 2'b00);

        // err_clr coinciding with a fresh pattern error: bit1 clears, bit0 sets.
        drive(PAT[8], 4'b0110, 3);
        drive(7'b0, 4'b0, 1);
        check("pre clr err", 32'(bus.err_status), 32'h2);
        bus.seg    = BAD;
        bus.dig_en = 4'b0001;
        tick();
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("clr vs err", 32'(bus.err_status), 32'h1);
        drive(7'b0, 4'b0, 2);
        check("clr vs err hold", 32'(bus.err_status), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reverse direction of the BCD-to-7-segment path: watches a multiplexed 7-segment display bus (segment lines plus one-hot digit enables) and reconstructs the BCD digit values.
- Debounces each digit slot, decodes the segment pattern to BCD, and assembles a full display frame.
- Publishes frames atomically with a one-cycle valid pulse.
- Used as a display loop-back checker and as a front-end for reading external 7-segment panels.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; legal range 1..8.
- STABLE_CYCLES, 3, consecutive identical samples required before a capture; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous active-high reset.
- seg  input  7  segment lines {a,b,c,d,e,f,g}, active-high, a = bit 6.
- dig_en  input  NUM_DIGITS  digit enables, active-high, one-hot when driving.
- err_clr  input  1  clears err_status.
- bcd_out  output  4*NUM_DIGITS  frame digits; digit i occupies bits [4i+3:4i].
- blank_out  output  NUM_DIGITS  digit i was blank (all segments off).
- digit_err  output  NUM_DIGITS  digit i held an undecodable pattern.
- frame_valid  output  1  one-cycle pulse when a new frame is published.
- err_status  output  2  sticky flags: bit0 = pattern error, bit1 = enable/sequence error.

Behaviour:
- Reset: all outputs 0 (bcd_out, blank_out, digit_err, frame_valid, err_status). Sample registers 0, state SEEK, partial frame discarded.
- Sampling:
  - {seg, dig_en} is registered every cycle into the sample register.
  - Run counter: 1 when the new sample differs from the previous one, otherwise increment, saturating at STABLE_CYCLES.
  - Capture strobe fires on the cycle the counter first reaches STABLE_CYCLES. At most one capture per stable run.
- Capture qualification:
  - dig_en == 0: blanking interval; no capture, no error.
  - dig_en multi-hot: set err_status[1]; no capture.
  - dig_en one-hot at index k: capture digit k.
- Decode (segments → BCD):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9.
  - 0000000: nibble F, blank bit set.
  - Any other pattern: nibble F, digit_err bit set, err_status[0] set.
  - Decoded nibble, blank bit and error bit go to shadow registers, not to outputs.
- Frame FSM:
  - SEEK: a capture at k=0 stores the digit and goes to COLLECT with expected=1. Captures at k≠0 are ignored silently.
  - COLLECT:
    - k==expected: store digit, expected++.
    - k==expected-1 (same digit re-shown after a change): overwrite the stored digit, no error.
    - k==0: restart the frame, store digit 0, expected=1, no error.
    - Any other k: set err_status[1], discard the partial frame, go to SEEK.
  - When digit NUM_DIGITS-1 is stored, go to PUBLISH.
  - PUBLISH (one cycle): copy shadow to bcd_out/blank_out/digit_err, frame_valid=1, then SEEK.
  - NUM_DIGITS=1: every valid capture goes directly to PUBLISH.
- Latency: last digit stable at its first sampling edge E → capture at edge E+STABLE_CYCLES-1 → outputs and frame_valid updated at edge E+STABLE_CYCLES.
- Outputs hold their values between frames. A PUBLISH changes all fields together; no partial update is ever visible.
- err_status: bits stay set until err_clr. If err_clr and a new error occur in the same cycle, the error wins (bit ends set). err_clr has no effect on the FSM.
- rst mid-frame: immediate return to reset state; the next frame must start at digit 0.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=3; drive digits 0..3 in order with patterns for 1,2,3,4, each held 5 cycles with 1 blank cycle (dig_en=0) between → exactly one frame_valid, bcd_out=16'h4321, blank_out=0, digit_err=0, err_status=0. frame_valid appears 3 edges after digit 3 is first sampled.
- Glitch: digit 1 shows 1111001 for 2 cycles, then 1101101 held 5 cycles → bcd_out nibble 1 = 2, no error.
- Digit 2 shows 1001001 → nibble 2 = F, digit_err=4'b0100, err_status=2'b01. Flag persists after the next good frame; clears one cycle after an err_clr pulse.
- Digit 3 shows 0000000 → nibble 3 = F, blank_out=4'b1000, digit_err=0, err_status=0.
- Capture digits 0,1,3, then a full ordered frame → err_status[1]=1, no frame_valid for the bad sequence, then one frame_valid with correct data. Separately, dig_en=4'b0110 stable for 3 cycles → err_status[1]=1, no capture.
- Assert rst after digits 0,1 are captured; then drive digits 2,3 and a full frame → all outputs 0 during and after reset, no frame from the 2,3 fragment, one frame_valid for the full frame. Also pulse err_clr in the same cycle as a new pattern error → err_status[0] stays 1.
